// File: rtl/axis_rx_frame_filter_if.sv
// rtl/axis_rx_frame_filter_if.sv - 64-bit AXI-Stream beat bundle shared by rx and tx sides
// Signals: tvalid, tready, tdata[63:0], tkeep[7:0], tlast, tuser.
// Modports: master drives the beat and receives tready; slave is the mirror.
interface axis_rx_frame_filter_if;
    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tuser;

    modport master (output tvalid, output tdata, output tkeep, output tlast, output tuser,
                    input  tready);
    modport slave  (input  tvalid, input  tdata, input  tkeep, input  tlast, input  tuser,
                    output tready);
endinterface

// File: rtl/axis_rx_frame_filter.sv
// rtl/axis_rx_frame_filter.sv - store-and-forward rx frame filter with good/drop counters
// Ports: clk156, rst_n (sync, active-low); s_axis (slave, rx from MAC, never backpressured);
//        m_axis (master, clean frames toward the bridge, tuser always 0);
//        stat_good / stat_drop (32-bit wrapping frame counters).
module axis_rx_frame_filter #(
    parameter int DEPTH     = 512,
    parameter int MAX_WORDS = 190
) (
    input  logic                          clk156,
    input  logic                          rst_n,
    axis_rx_frame_filter_if.slave         s_axis,
    axis_rx_frame_filter_if.master        m_axis,
    output logic [31:0]                   stat_good,
    output logic [31:0]                   stat_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(MAX_WORDS + 1);
    localparam int WW = 1 + 8 + 64;

    typedef enum logic [1:0] {IDLE, ACTIVE, DROP} wstate_t;

    logic [WW-1:0] mem_q [DEPTH];

    wstate_t       state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [LW-1:0] wlen_q, wlen_d;
    logic [31:0]   good_q, drop_q;
    logic          good_inc, drop_inc, wr_en;
    logic          tready_q;

    // fetch_ptr addresses the memory; rd_ptr only moves when a word leaves
    // m_axis, so words sitting in the read pipeline still occupy space.
    logic [PW-1:0] fetch_ptr_q, rd_ptr_q;
    logic          s1_v_q, out_v_q;
    logic [WW-1:0] s1_q, out_q;

    logic [PW-1:0] used;
    logic          full, accept, out_fire, s1_move, fetch;

    assign accept   = s_axis.tvalid && tready_q;
    assign used     = wr_ptr_q - rd_ptr_q;
    assign full     = (used == PW'(DEPTH));

    assign out_fire = out_v_q && m_axis.tready;
    assign s1_move  = s1_v_q && (!out_v_q || m_axis.tready);
    assign fetch    = (fetch_ptr_q != commit_ptr_q) && (!s1_v_q || s1_move);

    assign s_axis.tready = tready_q;
    assign m_axis.tvalid = out_v_q;
    assign m_axis.tlast  = out_q[72];
    assign m_axis.tkeep  = out_q[71:64];
    assign m_axis.tdata  = out_q[63:0];
    assign m_axis.tuser  = 1'b0;
    assign stat_good     = good_q;
    assign stat_drop     = drop_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        wlen_d       = wlen_q;
        good_inc     = 1'b0;
        drop_inc     = 1'b0;
        wr_en        = 1'b0;
        if (accept) begin
            if (state_q == DROP) begin
                if (s_axis.tlast) begin
                    wr_ptr_d = commit_ptr_q;
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end
            end else if (full || (wlen_q >= LW'(MAX_WORDS))) begin
                wlen_d = '0;
                if (s_axis.tlast) begin
                    wr_ptr_d = commit_ptr_q;
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d  = DROP;
                end
            end else begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (s_axis.tlast) begin
                    wlen_d  = '0;
                    state_d = IDLE;
                    if (!s_axis.tuser) begin
                        commit_ptr_d = wr_ptr_q + 1'b1;
                        good_inc     = 1'b1;
                    end else begin
                        wr_ptr_d = commit_ptr_q;
                        drop_inc = 1'b1;
                    end
                end else begin
                    wlen_d  = wlen_q + 1'b1;
                    state_d = ACTIVE;
                end
            end
        end
    end

    always_ff @(posedge clk156) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            wlen_q       <= '0;
            good_q       <= '0;
            drop_q       <= '0;
            tready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            wlen_q       <= wlen_d;
            good_q       <= good_q + 32'(good_inc);
            drop_q       <= drop_q + 32'(drop_inc);
            tready_q     <= 1'b1;
        end
    end

    always_ff @(posedge clk156) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
        end
    end

    always_ff @(posedge clk156) begin
        if (fetch) begin
            s1_q <= mem_q[fetch_ptr_q[AW-1:0]];
        end
    end

    // Two-stage read: registered memory word (s1) feeding the output holding
    // register. s1 refills in the cycle it drains, giving 1 word/cycle.
    always_ff @(posedge clk156) begin
        if (!rst_n) begin
            fetch_ptr_q <= '0;
            rd_ptr_q    <= '0;
            s1_v_q      <= 1'b0;
            out_v_q     <= 1'b0;
            out_q       <= '0;
        end else begin
            if (fetch) begin
                fetch_ptr_q <= fetch_ptr_q + 1'b1;
            end
            if (out_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (fetch) begin
                s1_v_q <= 1'b1;
            end else if (s1_move) begin
                s1_v_q <= 1'b0;
            end
            if (!out_v_q || m_axis.tready) begin
                out_v_q <= s1_v_q;
                if (s1_v_q) begin
                    out_q <= s1_q;
                end
            end
        end
    end
endmodule

// File: doc/axis_rx_frame_filter.md
Name: axis_rx_frame_filter

Overview:
Per-port store-and-forward receive stage on the 156.25 MHz 64-bit AXI-Stream path. It sits between a PHY/MAC rx stream and the port bridge, and buffers each frame completely before release. Frames flagged bad (tuser on last beat), oversized frames, and frames that overflow the buffer are discarded. Only clean frames are presented downstream, with tuser forced to 0; good and dropped frames are counted.

Parameters:
DEPTH, 512, buffer capacity in 64-bit words; power of 2, minimum 16
MAX_WORDS, 190, largest accepted frame in words (1518 B ≈ 190 words); frame with word count > MAX_WORDS is dropped

Ports:
clk156  in  1  single clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
s_axis_tvalid  in  1  rx beat valid
s_axis_tready  out  1  rx ready
s_axis_tdata  in  64  rx data
s_axis_tkeep  in  8  rx byte enables
s_axis_tlast  in  1  rx end of frame
s_axis_tuser  in  1  rx error flag; sampled on tlast beat only
m_axis_tvalid  out  1  tx beat valid toward bridge
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  64  tx data
m_axis_tkeep  out  8  tx byte enables
m_axis_tlast  out  1  tx end of frame
m_axis_tuser  out  1  always 0
stat_good  out  32  count of frames committed
stat_drop  out  32  count of frames dropped (any reason)

Behaviour:
- Clock/reset: one clock (clk156); reset is synchronous and active-low (rst_n). While rst_n=0 at an edge, all outputs are 0, both counters are 0, pointers are cleared and the write FSM is in IDLE. Any frame partly written or partly read is discarded with no count. s_axis_tready rises on the first edge with rst_n=1 and then stays 1; the input is never backpressured.
- Storage: {tlast, tkeep, tdata} per word. The pointers wr_ptr, commit_ptr and rd_ptr are log2(DEPTH)+1 bits wide. Used = wr_ptr − rd_ptr mod 2^(log2(DEPTH)+1). Full when used == DEPTH.
- Write FSM, states IDLE, ACTIVE and DROP. Every accepted beat increments wlen (frame word count, reset to 0 at frame end).
- IDLE/ACTIVE, beat accepted:
  - If full, or wlen+1 > MAX_WORDS: the beat is not written. If tlast, rollback now; otherwise go to DROP.
  - Otherwise the beat is written and wr_ptr increments. If tlast with tuser=0: commit_ptr ← wr_ptr+1, stat_good+1, go to IDLE. If tlast with tuser=1: rollback.
  - Without tlast the FSM moves to or stays in ACTIVE.
- DROP: beats are accepted and discarded. On the tlast beat, rollback.
- Rollback: wr_ptr ← commit_ptr, stat_drop+1, go to IDLE.
- Single-beat frames are legal. Back-to-back frames need no idle cycle.
- Read side: only words in [rd_ptr, commit_ptr) are visible. The memory read is registered with an output holding register, and the output obeys AXIS rules: tdata/tkeep/tlast are stable while tvalid=1 and tready=0. Throughput is 1 word/cycle with tready held high.
- Latency: with the output empty, m_axis_tvalid asserts exactly 2 cycles after the edge at which the good frame's tlast beat was accepted.
- Simultaneous events:
  - A read and a write in the same cycle are both performed.
  - A commit and a read in the same cycle are fine. A read never passes commit_ptr.
  - A rollback never touches committed words. A full buffer with a frame still draining is safe because rd_ptr frees space one word/cycle, but full is evaluated per beat at the accept edge.
- Frame larger than DEPTH: always overflows, is dropped and counted once.
- Counters wrap modulo 2^32. Exactly one of stat_good or stat_drop increments per input frame.
- First beats after reset release are treated as the start of a new frame.

Test Plan:
- Good frames: 3 frames of 8, 1 and 190 words, tuser=0, m_axis_tready=1 → identical data/tkeep/tlast out, first out beat 2 cycles after the first tlast, stat_good=3, stat_drop=0.
- Bad frame: a 10-word frame with tuser=1 on tlast, then a 4-word good frame → only the 4-word frame appears, stat_drop=1, stat_good=1, wr_ptr restored.
- Oversize: a 191-word frame with MAX_WORDS=190 → no output, stat_drop=1; a following 190-word frame passes.
- Overflow: DEPTH=16, m_axis_tready=0, write a 10-word good frame, then a 10-word frame → second dropped at beat 7, stat_drop=1. Release tready → exactly 10 words out, last with tlast=1.
- Backpressure: random m_axis_tready, 50 random-length good frames → byte-exact in-order output, payload stable under stall, m_axis_tuser never 1.
- Reset mid-frame: rst_n=0 for 1 cycle during word 5 of a frame, with 2 committed frames unread → no output, counters 0, s_axis_tready=0 during reset and 1 after.
